// File: rtl/fwd_pkg.sv
// Shared types for the EX operand forwarding controller: mux select codes,
// pipeline stage record and the zero-register index.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_IMM   = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_info_t;

  function automatic logic is_fwd(input fwd_sel_t s);
    return (s == FWD_EXMEM) || (s == FWD_MEMWB);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational forwarding match of one source register against the
// instructions currently in EX and MEM; the EX producer is the newer one.
module fwd_match
  import fwd_pkg::*;
#(
  parameter logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG)
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  stage_info_t           ex,
  input  stage_info_t           mem,
  output fwd_sel_t              sel
);

  // Load-ness does not affect the select; stall logic covers load-use.
  logic unused_memread;
  assign unused_memread = ex.memread ^ mem.memread;

  always_comb begin
    sel = FWD_RF;
    if (src != ZERO_IDX) begin
      if (ex.valid && ex.regwrite && ex.rd == src)
        sel = FWD_EXMEM;
      else if (mem.valid && mem.regwrite && mem.rd == src)
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Registered EX operand-mux select generation with load-use stall detection.
// Optional perf counters enabled by macro OPERAND_FWD_PERF_CNT_EN.
module operand_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31
`ifdef OPERAND_FWD_PERF_CNT_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_use_imm,
  input  logic                  flush,
  output logic [1:0]            ex_sel_a,
  output logic [1:0]            ex_sel_b,
  output logic                  ex_valid,
  output logic                  stall
`ifdef OPERAND_FWD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    fwd_count
  , output logic [CNT_W-1:0]    stall_count
`endif
);
  import fwd_pkg::*;

  localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

  stage_info_t ex_q, mem_q;
  fwd_sel_t    sel_a_q, sel_b_q, match_a, match_b, sel_b_d;
  logic        hazard, advance;

  fwd_match #(.ZERO_IDX(ZR)) u_match_a (.src(id_rn), .ex(ex_q), .mem(mem_q), .sel(match_a));
  fwd_match #(.ZERO_IDX(ZR)) u_match_b (.src(id_rm), .ex(ex_q), .mem(mem_q), .sel(match_b));

  assign sel_b_d = id_use_imm ? FWD_IMM : match_b;

  // A load in EX cannot supply its data to the next instruction in time.
  assign hazard  = ex_q.valid && ex_q.memread && (ex_q.rd != ZR) &&
                   ((ex_q.rd == id_rn) || (ex_q.rd == id_rm && !id_use_imm));
  assign stall   = reset_n && id_valid && !flush && hazard;
  assign advance = id_valid && !flush && !stall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else begin
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite, memread: 1'b0};
      if (advance) begin
        ex_q    <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
        sel_a_q <= match_a;
        sel_b_q <= sel_b_d;
      end else begin
        ex_q    <= '0;
        sel_a_q <= FWD_RF;
        sel_b_q <= FWD_RF;
      end
    end
  end

  assign ex_sel_a = sel_a_q;
  assign ex_sel_b = sel_b_q;
  assign ex_valid = ex_q.valid;

`ifdef OPERAND_FWD_PERF_CNT_EN
  logic fwd_hit;
  assign fwd_hit = advance && (is_fwd(match_a) || is_fwd(sel_b_d));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (fwd_hit && fwd_count != '1)
        fwd_count <= fwd_count + CNT_W'(1);
      if (stall && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed bench for operand_fwd_ctrl: a producer-window model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_operand_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0, id_use_imm = 1'b0, flush = 1'b0;
  logic [1:0] ex_sel_a, ex_sel_b;
  logic       ex_valid, stall;
`ifdef OPERAND_FWD_PERF_CNT_EN
  logic [15:0] fwd_count, stall_count;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit last_stall;

  operand_fwd_ctrl dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_use_imm(id_use_imm), .flush(flush),
    .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .ex_valid(ex_valid), .stall(stall)
`ifdef OPERAND_FWD_PERF_CNT_EN
    , .fwd_count(fwd_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: the two most recent instructions issued into EX (index 0 newest).
  bit       m_v[2]  = '{0, 0};
  bit [4:0] m_rd[2] = '{0, 0};
  bit       m_wr[2] = '{0, 0};
  bit       m_ld[2] = '{0, 0};
  bit [1:0] m_sa = 0, m_sb = 0;

  function automatic bit [1:0] m_fwd(input bit [4:0] s);
    bit [1:0] r = 2'b00;
    if (s != 5'd31)
      for (int k = 1; k >= 0; k--)
        if (m_v[k] && m_wr[k] && m_rd[k] == s) r = 2'(k + 1);
    return r;
  endfunction

  function automatic bit m_stall();
    return reset_n && id_valid && !flush && m_v[0] && m_ld[0] && m_rd[0] != 5'd31 &&
           (m_rd[0] == id_rn || (m_rd[0] == id_rm && !id_use_imm));
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_v  <= '{0, 0}; m_wr <= '{0, 0}; m_ld <= '{0, 0}; m_rd <= '{0, 0};
      m_sa <= 0; m_sb <= 0;
    end else begin
      m_v[1] <= m_v[0]; m_rd[1] <= m_rd[0]; m_wr[1] <= m_wr[0]; m_ld[1] <= 0;
      if (id_valid && !flush && !m_stall()) begin
        m_v[0] <= 1; m_rd[0] <= id_rd; m_wr[0] <= id_regwrite; m_ld[0] <= id_memread;
        m_sa <= m_fwd(id_rn);
        m_sb <= id_use_imm ? 2'b11 : m_fwd(id_rm);
      end else begin
        m_v[0] <= 0; m_rd[0] <= 0; m_wr[0] <= 0; m_ld[0] <= 0;
        m_sa <= 0; m_sb <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_stall",    int'(stall),    int'(m_stall()));
      chk("model_ex_valid", int'(ex_valid), int'(m_v[0]));
      chk("model_sel_a",    int'(ex_sel_a), int'(m_sa));
      chk("model_sel_b",    int'(ex_sel_b), int'(m_sb));
    end
  end

  // Present one ID slot for one clock; on return the EX outputs reflect it.
  task automatic drive(input bit v, input bit [4:0] rn, rm, rd,
                       input bit wr, ld, imm, fl);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_regwrite = wr; id_memread = ld; id_use_imm = imm; flush = fl;
    #1 last_stall = stall;
    @(negedge clk); #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input bit [4:0] rn, rm, rd);
    drive(1, rn, rm, rd, 1, 0, 0, 0);
  endtask

  task automatic ldur(input bit [4:0] rn, rd);
    drive(1, rn, 5'd0, rd, 1, 1, 1, 0);
  endtask

  initial begin
    // Reset held for two cycles under random ID traffic.
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk_en = 1'b1;
    end
    chk("rst_sel_a", int'(ex_sel_a), 0);
    chk("rst_sel_b", int'(ex_sel_b), 0);
    chk("rst_ex_valid", int'(ex_valid), 0);
    chk("rst_stall", int'(stall), 0);
    reset_n = 1'b1;
    nop();

    // Back-to-back dependency.
    alu(10, 11, 1);
    alu(1, 2, 7);
    chk("b2b_sel_a", int'(ex_sel_a), 1);
    chk("b2b_sel_b", int'(ex_sel_b), 0);
    nop(); nop();

    // Distance two, then newest-producer priority.
    alu(12, 13, 3); nop(); alu(3, 14, 8);
    chk("dist2_sel_a", int'(ex_sel_a), 2);
    nop(); nop();
    alu(12, 13, 3); alu(15, 16, 3); alu(3, 14, 8);
    chk("prio_sel_a", int'(ex_sel_a), 1);
    nop(); nop();

    // Load-use, from a fresh reset so the counters cover just this.
    reset_n = 1'b0; nop(); reset_n = 1'b1;
    ldur(0, 4);
    alu(4, 5, 9);
    chk("lu_stall", int'(last_stall), 1);
    chk("lu_bubble", int'(ex_valid), 0);
    alu(4, 5, 9);
    chk("lu_stall_once", int'(last_stall), 0);
    chk("lu_sel_a", int'(ex_sel_a), 2);
    chk("lu_ex_valid", int'(ex_valid), 1);
`ifdef OPERAND_FWD_PERF_CNT_EN
    chk("stall_count", int'(stall_count), 1);
    chk("fwd_count", int'(fwd_count), 1);
`endif
    nop(); nop();

    // Load followed by an immediate-B use of the same register.
    ldur(0, 4);
    drive(1, 0, 4, 10, 1, 0, 1, 0);
    chk("imm_no_stall", int'(last_stall), 0);
    chk("imm_sel_b", int'(ex_sel_b), 3);
    nop(); nop();

    // Zero register.
    alu(20, 21, 31); alu(31, 22, 9);
    chk("zr_sel_a", int'(ex_sel_a), 0);
    nop(); nop();
    ldur(0, 31); alu(31, 31, 9);
    chk("zr_no_stall", int'(last_stall), 0);
    chk("zr_ex_valid", int'(ex_valid), 1);
    nop(); nop();

    // Flush beats a load-use hazard.
    ldur(0, 6);
    drive(1, 6, 0, 9, 1, 0, 0, 1);
    chk("flush_stall", int'(last_stall), 0);
    chk("flush_bubble", int'(ex_valid), 0);
    alu(6, 0, 9);
    chk("flush_after_sel_a", int'(ex_sel_a), 2);
    nop(); nop();

    // Reset while a load sits in EX.
    ldur(0, 4);
    reset_n = 1'b0;
    alu(4, 4, 9);
    chk("mrst_stall", int'(last_stall), 0);
    chk("mrst_ex_valid", int'(ex_valid), 0);
    reset_n = 1'b1;
    alu(4, 4, 9);
    chk("mrst_no_stall", int'(last_stall), 0);
    chk("mrst_sel_a", int'(ex_sel_a), 0);
    chk("mrst_sel_b", int'(ex_sel_b), 0);
    nop(); nop();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fwd_ctrl.md
Name: operand_fwd_ctrl

Overview:
- Generates registered 2-bit select codes for the EX-stage operand muxes. Each mux is a 4:1 mux built from mux4_1 instances, one per data bit.
- Select encoding: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 immediate.
- Tracks destination/write info of in-flight instructions through EX and MEM, and detects load-use hazards.
- Sits between decode and the EX operand mux banks.

Parameters:
- REG_ADDR_W, 5, register address width.
- ZERO_REG, 31, hardwired-zero register; never forwarded, never a hazard.
- CNT_W, 16, performance counter width (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- id_valid  input  1  instruction present in ID
- id_rn  input  REG_ADDR_W  source A register
- id_rm  input  REG_ADDR_W  source B register
- id_rd  input  REG_ADDR_W  destination register
- id_regwrite  input  1  ID instruction writes the register file
- id_memread  input  1  ID instruction is a load
- id_use_imm  input  1  operand B is the immediate
- flush  input  1  squash the ID instruction (branch taken)
- ex_sel_a  output  2  select for operand-A mux bank
- ex_sel_b  output  2  select for operand-B mux bank
- ex_valid  output  1  EX holds a real instruction
- stall  output  1  hold PC and IF/ID; combinational

Behaviour:
- Clock and reset: all state updates on the rising edge of clk. Reset is synchronous; reset_n=0 at an edge clears it.
- Reset values: all stage valid bits 0, ex_sel_a=ex_sel_b=00, ex_valid=0, counters 0. stall=0 while reset_n=0.
- Stage registers:
  - EX holds {valid, rd, regwrite, memread}; MEM holds {valid, rd, regwrite}.
  - Every cycle EX shifts into MEM unconditionally.
- Forwarding match for source S (evaluated on ID inputs, registered into ex_sel_* at the edge where ID moves to EX):
  - S==ZERO_REG gives 00.
  - Else if the current EX stage is valid with regwrite and rd==S: 01, because next cycle it occupies EX/MEM.
  - Else if the current MEM stage is valid with regwrite and rd==S: 10.
  - Else 00.
  - EX/MEM has priority over MEM/WB (newest value wins).
- Operand B: id_use_imm=1 forces ex_sel_b=11, overriding any match.
- Write-back: the register file writes on the falling edge, so no WB-stage forwarding is generated.
- Load-use hazard: stall = id_valid & EX.valid & EX.memread & (EX.rd != ZERO_REG) & (EX.rd==id_rn | (EX.rd==id_rm & !id_use_imm)).
- Stall edge: EX loads a bubble (valid=0, regwrite=0, sels 00) and ID holds. Next cycle the load is in MEM and the match yields 10.
- Flush: flush=1 loads a bubble into EX and suppresses stall (stall forced 0). Flush has priority over stall.
- id_valid=0 also loads a bubble.
- Total latency: ID inputs to ex_sel_* is 1 cycle.

Optional Feature:
- Macro: OPERAND_FWD_PERF_CNT_EN.
- Defined:
  - Adds outputs fwd_count[CNT_W-1:0] and stall_count[CNT_W-1:0].
  - fwd_count increments once per cycle where a real instruction enters EX with ex_sel_a or ex_sel_b in {01,10}.
  - stall_count increments once per cycle with stall=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg:
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_IMM=2'b11}
  - ZERO_REG constant
  - packed struct stage_info_t {valid, rd, regwrite, memread}
- Sub-module fwd_match: combinational, one source against EX/MEM info returning fwd_sel_t. Instantiated twice, for A and B.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with random inputs -> ex_sel_a=ex_sel_b=00, ex_valid=0, stall=0.
- Back-to-back dependency: ADD X1 (rd=1, regwrite) then SUB rn=1, rm=2 -> at SUB's EX, ex_sel_a=01, ex_sel_b=00.
- Distance-2 and priority:
  - ADD X3, then NOP, then rn=3 -> ex_sel_a=10.
  - ADD X3, ADD X3, then rn=3 -> ex_sel_a=01.
- Load-use: LDUR rd=4 then ADD rn=4 -> stall=1 for exactly 1 cycle, bubble in EX (ex_valid=0), then ex_sel_a=10.
  - Same with rm=4 and id_use_imm=1 -> no stall, ex_sel_b=11.
- Zero register: ADD X31 (regwrite) then rn=31 -> ex_sel_a=00. LDUR X31 then use X31 -> no stall.
- Flush and reset mid-operation:
  - Load-use condition with flush=1 -> stall=0, ex_valid=0 next cycle.
  - reset_n=0 while a load is in EX -> next cycle all valid bits 0 and no forwarding from pre-reset instructions.
  - With OPERAND_FWD_PERF_CNT_EN: after the load-use test, stall_count=1 and fwd_count=1.
